led_matrix_scanner: RTL

Downstream display stage for the game levels. It takes the 8×8 three-bit-colour frame a level module drives every cycle and scans it row by row onto a daisy-chained serial-in/parallel-out LED driver (595-style) that feeds the 8×8 RGB matrix. Capture is double-buffered so the panel never shows a half-updated frame. The row multiplexing, serialisation and latch/blanking sequencing are owned here.

---
 rtl/led_matrix_scanner.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/led_matrix_scanner.sv
// Scans a double-buffered 8x8 RGB frame row by row into a 595-style chain.
// Optional PWM dimming during HOLD: define SCAN_BRIGHTNESS_EN.
module led_matrix_scanner #(
    parameter int CLK_DIV     = 2,
    parameter int HOLD_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0][23:0] frame_in,
    input  logic             frame_valid,
`ifdef SCAN_BRIGHTNESS_EN
    input  logic [3:0]       brightness,
`endif
    output logic             ser_data,
    output logic             ser_clk,
    output logic             ser_latch,
    output logic             ser_oe_n,
    output logic [2:0]       row_idx,
    output logic             frame_done
);

    localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
    localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        LOAD,
        SHIFT,
        LATCH,
        HOLD
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [15:0]      div_cnt;
    logic [15:0]      hold_cnt;
    logic             phase;
    logic [4:0]       bit_cnt;
    logic [2:0]       row_ptr;
    logic [31:0]      shreg;
    logic [7:0][23:0] shadow;
    logic [7:0][23:0] active;
    logic             pending;
    logic             lit;
    logic             div_end;
    logic             hold_end;
`ifdef SCAN_BRIGHTNESS_EN
    logic [3:0]       pwm_cnt;
    logic [3:0]       bright_q;
`endif

    function automatic logic [31:0] row_word(
        input logic [23:0] px,
        input logic [2:0]  r
    );
        logic [7:0] red;
        logic [7:0] grn;
        logic [7:0] blu;
        for (int k = 0; k < 8; k++) begin
            red[k] = px[3*k+2];
            grn[k] = px[3*k+1];
            blu[k] = px[3*k];
        end
        return {~(8'd1 << r), red, grn, blu};
    endfunction

    assign div_end  = (div_cnt == DIV_LAST);
    assign hold_end = (hold_cnt == HOLD_LAST);

    always_ff @(posedge clk) begin
        if (!rst) state <= LOAD;
        else      state <= state_n;
    end

    always_comb begin
        state_n    = state;
        ser_data   = 1'b0;
        ser_clk    = 1'b0;
        ser_latch  = 1'b0;
        ser_oe_n   = ~lit;
        frame_done = 1'b0;
        unique case (state)
            LOAD: state_n = SHIFT;
            SHIFT: begin
                ser_data = shreg[31];
                ser_clk  = phase;
                if (phase && div_end && bit_cnt == 5'd0)
                    state_n = LATCH;
            end
            LATCH: begin
                ser_latch = 1'b1;
                ser_oe_n  = 1'b1;
                if (div_end) state_n = HOLD;
            end
            HOLD: begin
`ifdef SCAN_BRIGHTNESS_EN
                ser_oe_n = (pwm_cnt >= bright_q);
`else
                ser_oe_n = 1'b0;
`endif
                frame_done = hold_end && (row_ptr == 3'd7);
                if (hold_end) state_n = LOAD;
            end
            default: state_n = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            div_cnt  <= '0;
            hold_cnt <= '0;
            phase    <= 1'b0;
            bit_cnt  <= '0;
            row_ptr  <= '0;
            row_idx  <= '0;
            shreg    <= '0;
            shadow   <= '0;
            active   <= '0;
            pending  <= 1'b0;
            lit      <= 1'b0;
`ifdef SCAN_BRIGHTNESS_EN
            pwm_cnt  <= '0;
            bright_q <= '0;
`endif
        end else begin
            if (frame_valid) begin
                shadow  <= frame_in;
                pending <= 1'b1;
            end
            // A capture in the swap cycle keeps pending for the next frame
            if (frame_done && pending) begin
                active <= shadow;
                if (!frame_valid) pending <= 1'b0;
            end
            unique case (state)
                LOAD: begin
                    shreg   <= row_word(active[row_ptr], row_ptr);
                    bit_cnt <= 5'd31;
                    div_cnt <= '0;
                    phase   <= 1'b0;
                end
                SHIFT: begin
                    if (div_end) begin
                        div_cnt <= '0;
                        phase   <= ~phase;
                        if (phase) begin
                            shreg   <= shreg << 1;
                            bit_cnt <= bit_cnt - 5'd1;
                            if (bit_cnt == 5'd0) row_idx <= row_ptr;
                        end
                    end else begin
                        div_cnt <= div_cnt + 16'd1;
                    end
                end
                LATCH: begin
                    if (div_end) begin
                        div_cnt  <= '0;
                        hold_cnt <= '0;
                        lit      <= 1'b1;
`ifdef SCAN_BRIGHTNESS_EN
                        pwm_cnt  <= '0;
                        bright_q <= brightness;
`endif
                    end else begin
                        div_cnt <= div_cnt + 16'd1;
                    end
                end
                HOLD: begin
`ifdef SCAN_BRIGHTNESS_EN
                    pwm_cnt <= pwm_cnt + 4'd1;
`endif
                    if (hold_end) row_ptr  <= row_ptr + 3'd1;
                    else          hold_cnt <= hold_cnt + 16'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
